// File: rtl/fsm_input_cond.sv
// Input conditioning for fsm_rtl: synchronizes raw start/done/fault, debounces
// start/done, holds a sticky fault flag and reports start edges and glitches.
module fsm_input_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 8,
  parameter int DEB_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_start,
  input  logic       raw_done,
  input  logic       raw_fault,
  input  logic       fault_clr,
  output logic       in_start,
  output logic       in_done,
  output logic       in_fault,
  output logic       start_rise,
  output logic [7:0] glitch_cnt
);

  localparam logic [DEB_W-1:0] C_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_start;
  logic [SYNC_STAGES-1:0] sync_done;
  logic [SYNC_STAGES-1:0] sync_fault;

  logic [1:0]       s_deb;
  logic [1:0]       y_q;
  logic [DEB_W-1:0] c_q [2];
  logic [1:0]       glitch;
  logic [8:0]       cnt_sum;
  logic [7:0]       glitch_q;
  logic             s_fault;
  logic             fault_q;
  logic             start_prev_q;
  logic             rise_q;

  // Channel 0 is start, channel 1 is done.
  assign s_deb   = {sync_done[SYNC_STAGES-1], sync_start[SYNC_STAGES-1]};
  assign s_fault = sync_fault[SYNC_STAGES-1];

  always_comb begin
    glitch = '0;
    for (int i = 0; i < 2; i++) begin
      glitch[i] = (s_deb[i] == y_q[i]) && (c_q[i] != '0);
    end
  end

  // Nine bits hold 255 + 2, so the saturation test is the carry bit.
  assign cnt_sum = {1'b0, glitch_q} + 9'(glitch[0]) + 9'(glitch[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_start <= '0;
      sync_done  <= '0;
      sync_fault <= '0;
    end else begin
      sync_start <= {sync_start[SYNC_STAGES-2:0], raw_start};
      sync_done  <= {sync_done[SYNC_STAGES-2:0], raw_done};
      sync_fault <= {sync_fault[SYNC_STAGES-2:0], raw_fault};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      for (int i = 0; i < 2; i++) begin
        c_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_deb[i] != y_q[i]) begin
          if (c_q[i] == C_LAST) begin
            y_q[i] <= s_deb[i];
            c_q[i] <= '0;
          end else begin
            c_q[i] <= c_q[i] + DEB_W'(1);
          end
        end else begin
          c_q[i] <= '0;
        end
      end
    end
  end

  // Set wins over clear; clear only acts once the synchronized fault is gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (s_fault) begin
      fault_q <= 1'b1;
    end else if (fault_clr) begin
      fault_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q     <= '0;
      start_prev_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      glitch_q     <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
      start_prev_q <= in_start;
      rise_q       <= in_start & ~start_prev_q;
    end
  end

  assign in_start   = y_q[0] & ~fault_q;
  assign in_done    = y_q[1];
  assign in_fault   = fault_q;
  assign start_rise = rise_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_fsm_input_cond.sv
// Scoreboard bench for fsm_input_cond: stimulus queues timed expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_fsm_input_cond;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw_start = 1'b0;
  logic       raw_done = 1'b0;
  logic       raw_fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic       in_start;
  logic       in_done;
  logic       in_fault;
  logic       start_rise;
  logic [7:0] glitch_cnt;

  fsm_input_cond #(.SYNC_STAGES(2), .DEB_CYCLES(8), .DEB_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_start (raw_start),
    .raw_done  (raw_done),
    .raw_fault (raw_fault),
    .fault_clr (fault_clr),
    .in_start  (in_start),
    .in_done   (in_done),
    .in_fault  (in_fault),
    .start_rise(start_rise),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  localparam int SEL_START = 0;
  localparam int SEL_DONE  = 1;
  localparam int SEL_FAULT = 2;
  localparam int SEL_RISE  = 3;
  localparam int SEL_GLCH  = 4;

  typedef struct {
    int    due;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sample(input int sel);
    case (sel)
      SEL_START: return int'(in_start);
      SEL_DONE:  return int'(in_done);
      SEL_FAULT: return int'(in_fault);
      SEL_RISE:  return int'(start_rise);
      default:   return int'(glitch_cnt);
    endcase
  endfunction

  // Monitor: compares every expectation due after the current edge.
  always @(negedge clk) begin
    exp_t keep[$];
    int   act;
    keep = {};
    foreach (sbq[i]) begin
      if (sbq[i].due == cyc) begin
        act = sample(sbq[i].sel);
        checks++;
        if (act != sbq[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %0d expected %0d", sbq[i].name, cyc, act, sbq[i].val);
        end
      end else if (sbq[i].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc %0d never sampled", sbq[i].name, sbq[i].due);
      end else begin
        keep.push_back(sbq[i]);
      end
    end
    sbq = keep;
  end

  task automatic expect_at(input int dly, input int sel, input int val, input string name);
    exp_t e;
    e.due  = cyc + dly;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    raw_start = 1'b0;
    raw_done  = 1'b0;
    raw_fault = 1'b0;
    fault_clr = 1'b0;
    wait_n(2);
    rst_n = 1'b1;
    wait_n(4);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all raw inputs high.
    raw_start = 1'b1;
    raw_done  = 1'b1;
    raw_fault = 1'b1;
    @(negedge clk);
    expect_at(1, SEL_START, 0, "rst_in_start");
    expect_at(1, SEL_DONE,  0, "rst_in_done");
    expect_at(1, SEL_FAULT, 0, "rst_in_fault");
    expect_at(1, SEL_RISE,  0, "rst_start_rise");
    expect_at(1, SEL_GLCH,  0, "rst_glitch_cnt");
    wait_n(3);
    rst_n = 1'b1;
    expect_at(2,  SEL_FAULT, 0, "rel_fault_e2");
    expect_at(3,  SEL_FAULT, 1, "rel_fault_e3");
    expect_at(9,  SEL_DONE,  0, "rel_done_e9");
    expect_at(10, SEL_DONE,  1, "rel_done_e10");
    expect_at(10, SEL_START, 0, "rel_start_masked_e10");
    expect_at(12, SEL_START, 0, "rel_start_masked_e12");
    expect_at(12, SEL_RISE,  0, "rel_no_rise");
    wait_n(14);

    // Clean start.
    do_reset();
    raw_start = 1'b1;
    expect_at(9,  SEL_START, 0, "clean_start_e9");
    expect_at(10, SEL_START, 1, "clean_start_e10");
    expect_at(10, SEL_RISE,  0, "clean_rise_e10");
    expect_at(11, SEL_RISE,  1, "clean_rise_e11");
    expect_at(12, SEL_RISE,  0, "clean_rise_e12");
    expect_at(12, SEL_GLCH,  0, "clean_glitch");
    wait_n(14);

    // Bounce: high 5, low 3, then steady high.
    do_reset();
    raw_start = 1'b1;
    expect_at(7,  SEL_GLCH,  0, "bounce_glitch_e7");
    expect_at(8,  SEL_GLCH,  1, "bounce_glitch_e8");
    expect_at(17, SEL_START, 0, "bounce_start_e17");
    expect_at(18, SEL_START, 1, "bounce_start_e18");
    expect_at(18, SEL_GLCH,  1, "bounce_glitch_e18");
    wait_n(5);
    raw_start = 1'b0;
    wait_n(3);
    raw_start = 1'b1;
    wait_n(12);

    // 300 more short low pulses, checked at 201 and at saturation.
    for (int i = 0; i < 300; i++) begin
      raw_start = 1'b0;
      wait_n(3);
      raw_start = 1'b1;
      wait_n(4);
      if (i == 199) begin
        wait_n(6);
        expect_at(1, SEL_GLCH, 201, "glitch_cnt_201");
        wait_n(2);
      end
    end
    wait_n(6);
    expect_at(1, SEL_GLCH,  255, "glitch_cnt_sat");
    expect_at(1, SEL_START, 1,   "start_held_through_glitches");
    wait_n(3);

    // Fault during run.
    do_reset();
    raw_start = 1'b1;
    wait_n(14);
    raw_fault = 1'b1;
    expect_at(2, SEL_START, 1, "fault_start_e2");
    expect_at(2, SEL_FAULT, 0, "fault_flag_e2");
    expect_at(3, SEL_FAULT, 1, "fault_flag_e3");
    expect_at(3, SEL_START, 0, "fault_mask_e3");
    wait_n(4);
    fault_clr = 1'b1;
    expect_at(1, SEL_FAULT, 1, "clr_while_fault_e1");
    expect_at(2, SEL_FAULT, 1, "clr_while_fault_e2");
    wait_n(1);
    fault_clr = 1'b0;
    wait_n(1);
    raw_fault = 1'b0;
    wait_n(3);
    fault_clr = 1'b1;
    expect_at(0, SEL_FAULT, 1, "pre_clear_fault");
    expect_at(1, SEL_FAULT, 0, "clear_fault_e1");
    expect_at(1, SEL_START, 1, "clear_start_e1");
    expect_at(1, SEL_RISE,  0, "clear_rise_e1");
    expect_at(2, SEL_RISE,  1, "clear_rise_e2");
    expect_at(3, SEL_RISE,  0, "clear_rise_e3");
    wait_n(1);
    fault_clr = 1'b0;
    wait_n(4);

    // Clear held across the edge where the synchronized fault appears.
    do_reset();
    raw_fault = 1'b1;
    wait_n(1);
    fault_clr = 1'b1;
    expect_at(2, SEL_FAULT, 1, "simul_set_clr_e3");
    expect_at(3, SEL_FAULT, 1, "simul_set_clr_e4");
    wait_n(3);
    fault_clr = 1'b0;
    wait_n(2);

    // Reset in the middle of a done debounce.
    do_reset();
    raw_done = 1'b1;
    wait_n(5);
    rst_n = 1'b0;
    expect_at(1, SEL_DONE, 0, "mid_rst_done_in_rst");
    wait_n(1);
    rst_n = 1'b1;
    expect_at(4,  SEL_DONE, 0, "mid_rst_done_old_e10");
    expect_at(9,  SEL_DONE, 0, "mid_rst_done_e9");
    expect_at(10, SEL_DONE, 1, "mid_rst_done_e10");
    expect_at(10, SEL_GLCH, 0, "mid_rst_glitch");
    wait_n(13);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_input_cond.md
# fsm_input_cond

Input conditioning stage that sits directly upstream of `fsm_rtl` and drives its `in_start`, `in_done` and `in_fault` inputs. Raw start/done/fault lines arrive asynchronous to `clk` and may bounce. They pass through multi-flop synchronizers. Start and done are debounced. Fault is latched as a sticky flag with a software clear. A one-cycle start-edge pulse and a saturating glitch counter are provided for status and debug.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth per raw input; must be ≥ 2.
- `DEB_CYCLES`, 8: number of consecutive cycles a synchronized level must differ from the filtered level before the filtered level is accepted; must be ≥ 1.
- `DEB_W`, 4: debounce counter width; 2^DEB_W ≥ DEB_CYCLES.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `raw_start`  in  1  asynchronous start request.
- `raw_done`  in  1  asynchronous done indication.
- `raw_fault`  in  1  asynchronous fault indication.
- `fault_clr`  in  1  synchronous fault-clear request, sampled each `clk` edge.
- `in_start`  out  1  filtered start level, masked by the fault flag; drives the FSM.
- `in_done`  out  1  filtered done level; drives the FSM.
- `in_fault`  out  1  sticky fault flag; drives the FSM.
- `start_rise`  out  1  one-cycle pulse on each 0→1 transition of `in_start`.
- `glitch_cnt`  out  8  saturating count of rejected start/done transitions.

## Operation
- Reset (`rst_n`=0, asynchronous): all synchronizer flops, filtered levels, debounce counters, the fault flag and `glitch_cnt` clear to 0. Every output reads 0 while in reset. Reset asserted mid-debounce discards the partial count.
- Synchronizer: each raw input passes through `SYNC_STAGES` flops. Call the last-stage output `s`.
- Debounce, applied to start and done independently. Each channel has a filtered level `y` and a counter `c`.
  - On an edge where `s` ≠ `y`: if `c` == `DEB_CYCLES`-1, then `y` ← `s` and `c` ← 0. Otherwise `c` ← `c`+1.
  - On an edge where `s` == `y`: `c` ← 0. If `c` was nonzero, the edge counts as one glitch for that channel.
- Fault flag, which has no debounce:
  - Set when synchronized fault = 1.
  - Else cleared when `fault_clr` = 1 and synchronized fault = 0.
  - Else holds.
  - Set has priority over clear. `fault_clr` has no effect while the flag is already 0.
- `in_start` = filtered start AND NOT `in_fault`. This guarantees the FSM's fault-exit condition (start = 0) while a fault is present.
- `in_done` = filtered done. It is not masked.
- `start_rise`: registered. Asserted for exactly one cycle after `in_start` goes 0→1, including when the rise is caused by the fault flag clearing while filtered start = 1.
- `glitch_cnt`: adds the number of channels that glitch on a given edge (0, 1 or 2). Saturates at 255 and never wraps. It is cleared only by reset.

## Timing
- Count `clk` edges starting with the first edge that samples the new raw level.
- Start/done latency: `in_start`/`in_done` change after edge `SYNC_STAGES`+`DEB_CYCLES`. With defaults this is the 10th edge.
- Fault set latency: `in_fault` rises after edge `SYNC_STAGES`+1, which is the 3rd edge with defaults.
- Fault clear: `in_fault` falls on the edge that samples `fault_clr` = 1 with synchronized fault = 0. This is 1 cycle.
- `in_start` masking is combinational from `in_fault`, so there is no extra cycle. `start_rise` lags `in_start` by one register.
- With `DEB_CYCLES` = 1, the filtered level follows `s` on the first differing edge.
- Pulses on a raw input shorter than `DEB_CYCLES` cycles after synchronization never reach `in_start`/`in_done`.

## Test plan
- Reset with all raw inputs = 1, then release `rst_n`: all outputs = 0 during reset. After release, `in_start`/`in_done` = 1 after edge 10, `in_fault` = 1 after edge 3, and `in_start` stays 0 because of the fault mask.
- Clean start with defaults: hold `raw_start` 0→1. `in_start` = 1 after exactly edge 10. `start_rise` is high for exactly one cycle on the following cycle. `glitch_cnt` = 0.
- Bounce: `raw_start` high for 5 cycles, low for 3, then high steadily. First `glitch_cnt` = 1, then `in_start` rises 10 edges after the final rise. Repeat 300 glitches and check `glitch_cnt` = 255 with no wrap.
- Fault during run: `in_start` = 1, then pulse `raw_fault` = 1. `in_fault` = 1 and `in_start` = 0 by edge 3. Assert `fault_clr` while `raw_fault` is still synchronized high: the flag stays 1. Drop `raw_fault`, then assert `fault_clr`: `in_fault` = 0 one cycle later, `in_start` = 1 and `start_rise` pulses.
- Simultaneous set and clear: `fault_clr` = 1 on the same edge that synchronized fault becomes 1. Required result: `in_fault` = 1.
- Mid-debounce reset: `raw_done` rises, and `rst_n` pulses low at edge 6. Required result: `in_done` = 0. After release, a fresh full 10-edge latency is measured from the next sampling edge.
